// File: rtl/cpu_instr_sequencer.sv
// rtl/cpu_instr_sequencer.sv - program store and word sequencer feeding the 4-bit accumulator CPU
module cpu_instr_sequencer #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [12:0]   load_word,
  output logic          load_ready,
  input  logic          clear,
  input  logic          start,
  input  logic          abort,
  output logic [3:0]    cpu_opcode,
  output logic [3:0]    cpu_data,
  output logic [3:0]    cpu_addr,
  output logic          cpu_we,
  output logic          issue_strobe,
  output logic [AW-1:0] pc,
  output logic [AW:0]   prog_len,
  output logic          busy,
  output logic          done
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [3:0] NOP_OP = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [AW:0]    prog_len_q, prog_len_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           fetch_q, fetch_d;
  logic           issue;

  logic [3:0]     op_q, op_d;
  logic [3:0]     data_q, data_d;
  logic [3:0]     addr_q, addr_d;
  logic           we_q, we_d;
  logic           strobe_q, strobe_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [12:0]    mem_q [DEPTH];
  logic [AW-1:0]  fetch_idx;
  logic [12:0]    fetch_word;
  logic           halt;
  logic           full;
  logic           accept;
  logic           pc_last;

  assign full       = (prog_len_q == (AW+1)'(DEPTH));
  assign load_ready = (state_q == S_IDLE) && !full && !start && !clear;
  assign accept     = load_valid && load_ready;
  assign pc_last    = ({1'b0, pc_q} == prog_len_q - (AW+1)'(1));

  // GAP fetches the following word so the next issue lands on the GAP exit edge.
  assign fetch_idx  = (state_q == S_GAP) ? pc_q + AW'(1) : pc_q;
  assign fetch_word = mem_q[fetch_idx];
  assign halt       = (fetch_word[11:8] == NOP_OP);

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[prog_len_q[AW-1:0]] <= load_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    prog_len_d = prog_len_q;
    hold_d     = hold_q;
    fetch_d    = fetch_q;
    issue      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          prog_len_d = '0;
        end else if (start) begin
          if (prog_len_q != '0) begin
            pc_d    = '0;
            fetch_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else if (accept) begin
          prog_len_d = prog_len_q + (AW+1)'(1);
        end
      end
      S_ISSUE: begin
        if (fetch_q) begin
          fetch_d = 1'b0;
          if (halt) begin
            state_d = S_DONE;
          end else begin
            issue = 1'b1;
          end
        end else if (hold_q == '0) begin
          state_d = S_GAP;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      S_GAP: begin
        if (pc_last) begin
          state_d = S_DONE;
        end else begin
          pc_d = pc_q + AW'(1);
          if (halt) begin
            state_d = S_DONE;
          end else begin
            issue   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
    if (issue) begin
      hold_d = HW'(HOLD_CYCLES - 1);
    end
    // Abort wins over everything once a run is in flight; pc stays on the interrupted word.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pc_d    = pc_q;
      hold_d  = hold_q;
      fetch_d = 1'b0;
      issue   = 1'b0;
    end
  end

  always_comb begin
    op_d     = NOP_OP;
    data_d   = '0;
    addr_d   = '0;
    we_d     = 1'b0;
    strobe_d = 1'b0;
    if (issue) begin
      we_d     = fetch_word[12];
      op_d     = fetch_word[11:8];
      data_d   = fetch_word[7:4];
      addr_d   = fetch_word[3:0];
      strobe_d = 1'b1;
    end else if ((state_q == S_ISSUE) && !fetch_q && (state_d == S_ISSUE)) begin
      we_d   = we_q;
      op_d   = op_q;
      data_d = data_q;
      addr_d = addr_q;
    end
    busy_d = (state_d == S_ISSUE) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      prog_len_q <= '0;
      hold_q     <= '0;
      fetch_q    <= 1'b0;
      op_q       <= NOP_OP;
      data_q     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      prog_len_q <= prog_len_d;
      hold_q     <= hold_d;
      fetch_q    <= fetch_d;
      op_q       <= op_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cpu_opcode   = op_q;
  assign cpu_data     = data_q;
  assign cpu_addr     = addr_q;
  assign cpu_we       = we_q;
  assign issue_strobe = strobe_q;
  assign pc           = pc_q;
  assign prog_len     = prog_len_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// tb/tb_cpu_instr_sequencer.sv - scoreboard bench for cpu_instr_sequencer
module tb_cpu_instr_sequencer;

  localparam int PERIOD = 4;
  localparam logic [12:0] NOP_W = 13'h0F00;

  typedef struct {int cyc; logic [12:0] w; int idx;} rec_t;
  typedef struct {int cyc; int pc;} done_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid, clear, start, abort;
  logic [12:0] load_word;
  logic        load_ready;
  logic [3:0]  cpu_opcode, cpu_data, cpu_addr;
  logic        cpu_we, issue_strobe, busy, done;
  logic [3:0]  pc;
  logic [4:0]  prog_len;

  cpu_instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_word(load_word),
    .load_ready(load_ready), .clear(clear), .start(start), .abort(abort),
    .cpu_opcode(cpu_opcode), .cpu_data(cpu_data), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .issue_strobe(issue_strobe), .pc(pc), .prog_len(prog_len), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  logic [12:0] prog[$];
  rec_t        iq[$];
  done_t       dq[$];
  rec_t        cur;
  int          run_k = 0, run_end = 0;
  int          model_pc = 0;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin : monitor
    rec_t r;
    done_t d;
    logic [12:0] ew;
    if (mon_en) begin
      if (issue_strobe) begin
        if (iq.size() == 0) chk("unexpected_strobe", 32'(issue_strobe), 32'(0));
        else begin
          r = iq.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(r.cyc));
          chk("strobe_pc", 32'(pc), 32'(r.idx));
          cur = r;
        end
      end
      if (done) begin
        if (dq.size() == 0) chk("unexpected_done", 32'(done), 32'(0));
        else begin
          d = dq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(d.cyc));
          chk("done_pc", 32'(pc), 32'(d.pc));
        end
      end
      ew = (cyc >= cur.cyc && cyc < cur.cyc + PERIOD - 1 && cyc < run_end) ? cur.w : NOP_W;
      chk("cpu_word", 32'({cpu_we, cpu_opcode, cpu_data, cpu_addr}), 32'(ew));
      chk("busy", 32'(busy), 32'(cyc >= run_k && cyc < run_end));
    end
  end

  function automatic logic [12:0] rand_word(input bit allow_halt);
    logic [12:0] w;
    w = 13'($urandom);
    if (allow_halt && $urandom_range(0, 7) == 0) w[11:8] = 4'hF;
    else w[11:8] = 4'($urandom_range(0, 14));
    return w;
  endfunction

  task automatic load_one(input logic [12:0] w);
    bit exp_rdy;
    @(negedge clk);
    load_valid = 1'b1;
    load_word  = w;
    #1;
    exp_rdy = (prog.size() < 16);
    chk("load_ready", 32'(load_ready), 32'(exp_rdy));
    @(negedge clk);
    load_valid = 1'b0;
    if (exp_rdy) prog.push_back(w);
    chk("prog_len", 32'(prog_len), 32'(prog.size()));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("load_ready_clear", 32'(load_ready), 32'(0));
    @(negedge clk);
    clear = 1'b0;
    prog.delete();
    #1;
    chk("prog_len_clear", 32'(prog_len), 32'(0));
    chk("load_ready_after_clear", 32'(load_ready), 32'(1));
  endtask

  // Expected schedule: strobe i at k+1+PERIOD*i; run ends at done or at the abort edge.
  task automatic launch(input int abort_after);
    int k, n, h, len, de, a, cy;
    bit ab;
    rec_t r;
    len = prog.size();
    n = 0;
    h = -1;
    for (int i = 0; i < len; i++) begin
      if (prog[i][11:8] == 4'hF) begin
        h = i;
        break;
      end
      n++;
    end
    @(negedge clk);
    start = 1'b1;
    k  = cyc + 1;
    de = (len == 0) ? k : k + 1 + PERIOD * n;
    a  = k + abort_after;
    ab = (abort_after > 0) && (a <= de);
    if (ab) model_pc = 0;
    for (int i = 0; i < n; i++) begin
      cy = k + 1 + PERIOD * i;
      if (!ab || cy < a) begin
        r.cyc = cy;
        r.w   = prog[i];
        r.idx = i;
        iq.push_back(r);
        if (ab) model_pc = i;
      end
    end
    if (ab) run_end = a;
    else begin
      if (len > 0) model_pc = (h >= 0) ? h : len - 1;
      dq.push_back('{de, model_pc});
      run_end = de;
    end
    run_k = k;
    @(negedge clk);
    start = 1'b0;
    if (ab) begin
      while (cyc < a - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    while (cyc < run_end + 3) @(negedge clk);
    chk("strobes_outstanding", 32'(iq.size()), 32'(0));
    chk("done_outstanding", 32'(dq.size()), 32'(0));
    chk("pc_end", 32'(pc), 32'(model_pc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cur.cyc = -100;
    cur.w = NOP_W;
    cur.idx = 0;
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_word = '0;
    clear = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_opcode", 32'(cpu_opcode), 32'(4'hF));
    chk("rst_data_addr_we", 32'({cpu_data, cpu_addr, cpu_we}), 32'(0));
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_prog_len", 32'(prog_len), 32'(0));
    chk("rst_flags", 32'({issue_strobe, busy, done}), 32'(0));
    chk("rst_load_ready", 32'(load_ready), 32'(1));
    mon_en = 1'b1;

    // three-word program, last word writes
    load_one(13'h0305);
    load_one(13'h0020);
    load_one(13'h1207);
    launch(0);

    // fill to capacity, hold a 17th word, then clear
    do_clear();
    for (int i = 0; i < 16; i++) load_one(rand_word(1'b1));
    @(negedge clk);
    load_valid = 1'b1;
    load_word = 13'h0ABC;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_load_ready", 32'(load_ready), 32'(0));
      chk("full_prog_len", 32'(prog_len), 32'(16));
      @(negedge clk);
    end
    load_valid = 1'b0;
    do_clear();

    // empty program: immediate done
    launch(0);

    // halt word stops the run before word 2
    load_one(13'h0311);
    load_one(13'h1F00);
    load_one(13'h0122);
    launch(0);
    chk("halt_pc", 32'(pc), 32'(1));

    // abort in the second hold cycle of word 1, then rerun
    do_clear();
    for (int i = 0; i < 3; i++) load_one(rand_word(1'b0));
    launch(1 + PERIOD + 2);
    chk("abort_pc", 32'(pc), 32'(1));
    launch(0);

    for (int it = 0; it < 12; it++) begin
      if (it == 0 || $urandom_range(0, 2) != 0) begin
        int len;
        do_clear();
        len = $urandom_range(0, 16);
        for (int i = 0; i < len; i++) load_one(rand_word(1'b1));
      end
      launch(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0);
    end

    // asynchronous reset in the middle of an issue
    do_clear();
    for (int i = 0; i < 3; i++) load_one(rand_word(1'b0));
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_opcode", 32'(cpu_opcode), 32'(prog[0][11:8]));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_opcode", 32'(cpu_opcode), 32'(4'hF));
    chk("async_rst_we", 32'(cpu_we), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_pc", 32'(pc), 32'(0));
    chk("async_rst_prog_len", 32'(prog_len), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    prog.delete();
    iq.delete();
    dq.delete();
    model_pc = 0;
    run_k = 0;
    run_end = 0;
    cur.cyc = -100;
    @(negedge clk);
    chk("post_reset_prog_len", 32'(prog_len), 32'(0));
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
